// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store initiator between the CPU pipeline and a synchronous-read RAM
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req_valid/req_ready       CPU request handshake (accepted when both high on a clk edge)
//   req_we, req_size          store/load select, access size (00 byte, 01 half, 10 word, 11 reserved)
//   req_unsigned              loads: 1 = zero-extend, 0 = sign-extend
//   req_addr, req_wdata       byte address, right-aligned store data
//   resp_valid/resp_ready     CPU response handshake
//   resp_rdata, resp_err      extended load data, misaligned/reserved-size flag
//   ram_wren, ram_address     RAM write enable, word-aligned RAM byte address
//   ram_write_data, ram_data  RAM write word, RAM read word (valid one cycle after address)
module mem_access_unit #(
    parameter int ADDR_W = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              ram_wren,
    output logic [ADDR_W-1:0] ram_address,
    output logic [31:0]       ram_write_data,
    input  logic [31:0]       ram_data
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        WRITE,
        RESP
    } state_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    state_t      state;
    logic        we_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [1:0]  lane_q;
    logic [15:0] wdata_q;
    logic        wren_q;

    logic        req_bad;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_ext;
    logic [31:0] merged;

    assign req_ready = (state == IDLE);

    // A write already registered for this cycle must not reach the RAM while reset is high.
    assign ram_wren = wren_q & ~rst;

    always_comb begin
        req_bad = 1'b0;
        case (req_size)
            SIZE_HALF: req_bad = req_addr[0];
            SIZE_WORD: req_bad = (req_addr[1:0] != 2'b00);
            SIZE_BYTE: req_bad = 1'b0;
            default:   req_bad = 1'b1;
        endcase
    end

    // Lane extraction and extension of the word arriving from the RAM in WAIT.
    always_comb begin
        byte_sel = 8'h00;
        case (lane_q)
            2'd0: byte_sel = ram_data[7:0];
            2'd1: byte_sel = ram_data[15:8];
            2'd2: byte_sel = ram_data[23:16];
            default: byte_sel = ram_data[31:24];
        endcase
        half_sel = lane_q[1] ? ram_data[31:16] : ram_data[15:0];

        load_ext = ram_data;
        case (size_q)
            SIZE_BYTE: load_ext = uns_q ? {24'h000000, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            SIZE_HALF: load_ext = uns_q ? {16'h0000, half_sel} : {{16{half_sel[15]}}, half_sel};
            default:   load_ext = ram_data;
        endcase
    end

    // Read-modify-write merge: only the addressed lane is replaced.
    always_comb begin
        merged = ram_data;
        if (size_q == SIZE_BYTE) begin
            case (lane_q)
                2'd0: merged[7:0]   = wdata_q[7:0];
                2'd1: merged[15:8]  = wdata_q[7:0];
                2'd2: merged[23:16] = wdata_q[7:0];
                default: merged[31:24] = wdata_q[7:0];
            endcase
        end else if (lane_q[1]) begin
            merged[31:16] = wdata_q;
        end else begin
            merged[15:0] = wdata_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            we_q           <= 1'b0;
            size_q         <= 2'b00;
            uns_q          <= 1'b0;
            lane_q         <= 2'b00;
            wdata_q        <= 16'h0000;
            wren_q         <= 1'b0;
            resp_valid     <= 1'b0;
            resp_err       <= 1'b0;
            resp_rdata     <= 32'h0;
            ram_address    <= '0;
            ram_write_data <= 32'h0;
        end else begin
            wren_q         <= 1'b0;
            ram_write_data <= 32'h0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        size_q  <= req_size;
                        uns_q   <= req_unsigned;
                        lane_q  <= req_addr[1:0];
                        wdata_q <= req_wdata[15:0];
                        if (req_bad) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= 32'h0;
                        end else begin
                            state       <= ISSUE;
                            ram_address <= {req_addr[ADDR_W-1:2], 2'b00};
                            // Full-word stores need no read, so the write goes out in ISSUE.
                            if (req_we && req_size == SIZE_WORD) begin
                                wren_q         <= 1'b1;
                                ram_write_data <= req_wdata;
                            end
                        end
                    end
                end
                ISSUE: begin
                    if (we_q && size_q == SIZE_WORD) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= 32'h0;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (we_q) begin
                        state          <= WRITE;
                        wren_q         <= 1'b1;
                        ram_write_data <= merged;
                    end else begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= load_ext;
                    end
                end
                WRITE: begin
                    state      <= RESP;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= 32'h0;
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit
module tb_mem_access_unit;

    localparam int ADDR_W = 20;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic              ram_wren;
    logic [ADDR_W-1:0] ram_address;
    logic [31:0]       ram_write_data;
    logic [31:0]       ram_data;

    int n_pass = 0;
    int n_total = 0;

    logic [31:0]       mem [0:255];
    logic [31:0]       rd_q = 32'h0;
    int                wr_count = 0;
    logic [ADDR_W-1:0] last_wr_addr = '0;
    logic [31:0]       last_wr_data = 32'h0;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(ADDR_W)) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we(req_we),
        .req_size(req_size),
        .req_unsigned(req_unsigned),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_rdata(resp_rdata),
        .resp_err(resp_err),
        .ram_wren(ram_wren),
        .ram_address(ram_address),
        .ram_write_data(ram_write_data),
        .ram_data(ram_data)
    );

    // Synchronous-read RAM: address captured every edge, data valid the next cycle.
    always @(posedge clk) begin
        if (ram_wren === 1'b1) begin
            mem[ram_address[9:2]] <= ram_write_data;
            wr_count     <= wr_count + 1;
            last_wr_addr <= ram_address;
            last_wr_data <= ram_write_data;
        end
        rd_q <= mem[ram_address[9:2]];
    end
    assign ram_data = rd_q;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Issue one request with resp_ready high; checks latency, data, error and write count.
    task automatic do_req(input string tag, input logic we, input logic [1:0] size,
                          input logic uns, input logic [ADDR_W-1:0] addr,
                          input logic [31:0] wdata, input int exp_lat,
                          input logic [31:0] exp_rdata, input logic exp_err,
                          input int exp_writes);
        int lat;
        int wr0;
        wr0 = wr_count;
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 1;
        while (resp_valid !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " rdata"}, resp_rdata, exp_rdata);
        check({tag, " err"}, {31'b0, resp_err}, {31'b0, exp_err});
        check({tag, " writes"}, wr_count - wr0, exp_writes);
        @(posedge clk);
        #1;
        check({tag, " idle after resp"}, {31'b0, req_ready}, 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h08]   = 32'h80F17F01;   // 0x20
        mem[8'h0C]   = 32'h11223344;   // 0x30
        mem[8'h14]   = 32'hCAFEBABE;   // 0x50
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = 32'h0;
        resp_ready   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        check("reset req_ready", {31'b0, req_ready}, 32'd1);
        check("reset resp_valid", {31'b0, resp_valid}, 32'd0);
        check("reset resp_rdata", resp_rdata, 32'h0);
        check("reset ram_wren", {31'b0, ram_wren}, 32'd0);
        check("reset ram_write_data", ram_write_data, 32'h0);
        check("reset ram_address", {12'b0, ram_address}, 32'h0);

        do_req("sw 0x10", 1'b1, 2'b10, 1'b0, 20'h00010, 32'hDEADBEEF, 2, 32'h0, 1'b0, 1);
        check("sw 0x10 wr addr", {12'b0, last_wr_addr}, 32'h10);
        check("sw 0x10 wr data", last_wr_data, 32'hDEADBEEF);
        do_req("lw 0x10", 1'b0, 2'b10, 1'b0, 20'h00010, 32'h0, 3, 32'hDEADBEEF, 1'b0, 0);

        do_req("lb 0x22", 1'b0, 2'b00, 1'b0, 20'h00022, 32'h0, 3, 32'hFFFFFFF1, 1'b0, 0);
        do_req("lbu 0x22", 1'b0, 2'b00, 1'b1, 20'h00022, 32'h0, 3, 32'h000000F1, 1'b0, 0);
        do_req("lh 0x22", 1'b0, 2'b01, 1'b0, 20'h00022, 32'h0, 3, 32'hFFFF80F1, 1'b0, 0);
        do_req("lhu 0x20", 1'b0, 2'b01, 1'b1, 20'h00020, 32'h0, 3, 32'h00007F01, 1'b0, 0);
        do_req("lb 0x23", 1'b0, 2'b00, 1'b0, 20'h00023, 32'h0, 3, 32'hFFFFFF80, 1'b0, 0);

        do_req("sb 0x31", 1'b1, 2'b00, 1'b0, 20'h00031, 32'h000000AA, 4, 32'h0, 1'b0, 1);
        check("sb 0x31 wr addr", {12'b0, last_wr_addr}, 32'h30);
        check("sb 0x31 wr data", last_wr_data, 32'h1122AA44);
        do_req("lw 0x30", 1'b0, 2'b10, 1'b0, 20'h00030, 32'h0, 3, 32'h1122AA44, 1'b0, 0);
        do_req("sh 0x32", 1'b1, 2'b01, 1'b0, 20'h00032, 32'h00005566, 4, 32'h0, 1'b0, 1);
        check("sh 0x32 wr data", last_wr_data, 32'h5566AA44);

        do_req("lw 0x42", 1'b0, 2'b10, 1'b0, 20'h00042, 32'h0, 1, 32'h0, 1'b1, 0);
        do_req("sh 0x43", 1'b1, 2'b01, 1'b0, 20'h00043, 32'h1234, 1, 32'h0, 1'b1, 0);
        do_req("size 11", 1'b0, 2'b11, 1'b0, 20'h00040, 32'h0, 1, 32'h0, 1'b1, 0);

        // Backpressure: response must hold while resp_ready is low.
        resp_ready   = 1'b0;
        req_valid    = 1'b1;
        req_we       = 1'b0;
        req_size     = 2'b10;
        req_unsigned = 1'b0;
        req_addr     = 20'h00010;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("bp first resp_valid", {31'b0, resp_valid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp resp_valid held", {31'b0, resp_valid}, 32'd1);
            check("bp rdata held", resp_rdata, 32'hDEADBEEF);
            check("bp req_ready low", {31'b0, req_ready}, 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp idle req_ready", {31'b0, req_ready}, 32'd1);
        check("bp idle resp_valid", {31'b0, resp_valid}, 32'd0);

        // Reset while the RMW write is on the RAM port.
        begin
            int wr0;
            wr0          = wr_count;
            req_valid    = 1'b1;
            req_we       = 1'b1;
            req_size     = 2'b00;
            req_addr     = 20'h00052;
            req_wdata    = 32'h00000011;
            @(posedge clk);
            #1;
            req_valid = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            check("rst-write wren before", {31'b0, ram_wren}, 32'd1);
            rst = 1'b1;
            #1;
            check("rst-write wren gated", {31'b0, ram_wren}, 32'd0);
            @(posedge clk);
            #1;
            rst = 1'b0;
            check("rst-write req_ready", {31'b0, req_ready}, 32'd1);
            check("rst-write resp_valid", {31'b0, resp_valid}, 32'd0);
            repeat (3) @(posedge clk);
            #1;
            check("rst-write no resp", {31'b0, resp_valid}, 32'd0);
            check("rst-write no writes", wr_count - wr0, 32'd0);
            check("rst-write ram word", mem[8'h14], 32'hCAFEBABE);
        end

        do_req("lw 0x50", 1'b0, 2'b10, 1'b0, 20'h00050, 32'h0, 3, 32'hCAFEBABE, 1'b0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store initiator between the CPU pipeline and the synchronous-read RAM.
- RAM contract: write on the `clk` edge when `wren` is high; read address captured on the `clk` edge, data valid the following cycle.
- Handles byte, halfword and word access in little-endian order, with sign/zero extension on loads.
- Sub-word stores use read-modify-write; misaligned requests are flagged as errors.
- CPU side uses a valid/ready request and valid/ready response handshake.

Parameters:
- ADDR_W, 20, byte-address width (equals `RAM_ADDRESS_BITWIDTH`).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept request
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as error)
- req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  response available
- resp_ready  in  1  CPU consumes response
- resp_rdata  out  32  extended load data (0 for stores and errors)
- resp_err  out  1  misaligned or reserved-size request
- ram_wren  out  1  RAM write enable
- ram_address  out  ADDR_W  RAM byte address, bits [1:0] always 0
- ram_write_data  out  32  RAM write word
- ram_data  in  32  RAM read word, valid one cycle after address capture

Behaviour:
- States: IDLE, ISSUE, WAIT, WRITE, RESP. All request fields are registered on acceptance.
- `req_ready` = (state == IDLE). A request is accepted on an edge where `req_valid && req_ready`.
- Alignment check on accept:
  - half requires addr[0] = 0; word requires addr[1:0] = 0; size 11 is always an error.
  - On error: go to RESP with `resp_err` = 1, `resp_rdata` = 0, no RAM access.
- IDLE → ISSUE on a valid accept.
- ISSUE:
  - `ram_address` = {addr[ADDR_W-1:2], 2'b00}.
  - Word store: `ram_wren` = 1, `ram_write_data` = wdata; next state RESP.
  - Load or sub-word store: `ram_wren` = 0; next state WAIT.
- WAIT:
  - `ram_data` is valid this cycle and is captured into an internal word register.
  - Load: extract lane, extend, write into `resp_rdata`; next state RESP.
  - Sub-word store: next state WRITE.
- Lane select (little-endian):
  - byte k = bits [8k+7:8k], k = addr[1:0].
  - half = bits [15:0] if addr[1] = 0, else bits [31:16].
- WRITE:
  - `ram_wren` = 1 for exactly one cycle, same `ram_address`.
  - `ram_write_data` = captured word with only the target byte/half lane replaced by wdata[7:0] or wdata[15:0].
  - Next state RESP.
- RESP:
  - `resp_valid` = 1; `resp_rdata` and `resp_err` held stable.
  - Leave to IDLE on an edge where `resp_ready` = 1.
  - No new request is accepted in the same cycle, so there is a minimum one idle cycle between requests.
- Latency from accept edge E0 to first `resp_valid` cycle (`resp_ready` = 1 throughout):
  - word store: 2 cycles
  - load: 3 cycles
  - sub-word store: 4 cycles
  - error: 1 cycle
- Outputs outside ISSUE/WRITE: `ram_wren` = 0, `ram_address` holds its last value, `ram_write_data` = 0.
- Reset:
  - state = IDLE; `resp_valid` = 0, `resp_err` = 0, `resp_rdata` = 0, `ram_write_data` = 0, `ram_address` = 0.
  - `ram_wren` is gated with !rst, so a write in flight when rst is high is suppressed in that same cycle.
  - Reset mid-operation discards the request; no response is produced.
- `req_valid` while busy is ignored (not accepted); the CPU must hold it.

Test Plan:
- Word store then load:
  - store addr 0x10, data 0xDEADBEEF → single-cycle `ram_wren`, address 0x10, write data 0xDEADBEEF, resp 2 cycles after accept.
  - load word 0x10 → `resp_rdata` 0xDEADBEEF, 3 cycles after accept.
- Sign/zero extension, RAM word 0x80F17F01 at 0x20:
  - lb 0x22 → 0xFFFFFFF1
  - lbu 0x22 → 0x000000F1
  - lh 0x22 → 0xFFFF80F1
  - lhu 0x20 → 0x00007F01
- Byte store RMW: word 0x11223344 at 0x30, sb 0x31 data 0xAA → one read, then one write of 0x1122AA44; a subsequent word load returns 0x1122AA44.
- Misaligned requests: lw 0x42, sh 0x43, size 11 → `resp_err` 1, `resp_rdata` 0, `ram_wren` never asserted, resp 1 cycle after accept.
- Backpressure: hold `resp_ready` 0 for 5 cycles after a load → `resp_valid` and `resp_rdata` stable, `req_ready` 0; IDLE one edge after `resp_ready` rises.
- Reset during WRITE of a sub-word store → `ram_wren` 0 in the reset cycle, RAM word unchanged, no `resp_valid`, `req_ready` 1 the cycle after.
